// File: rtl/coin_payer.sv
// coin_payer: pays an amount in dimes/nickels on the coin bus, then waits for dispense and reports status
module coin_payer #(
  parameter int AMT_W    = 4,
  parameter int COIN_GAP = 0,
  parameter int TIMEOUT  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             abort,
  input  logic             dispense,
  output logic [1:0]       coin,
  output logic             busy,
  output logic             done,
  output logic [1:0]       status,
  output logic [AMT_W-1:0] coins_sent
);
  localparam int CW = $clog2(TIMEOUT + 16) + 1;
  typedef enum logic [2:0] {IDLE, PAY, GAP, WAIT, DONE} state_t;
  state_t           state, state_nxt;
  logic [AMT_W-1:0] rem, rem_pay, rem_nxt, sent_base, sent_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [1:0]       status_nxt, coin_nxt;
  logic             pay_go;
  always_comb begin
    state_nxt  = state;
    rem_pay    = rem;
    cnt_nxt    = cnt;
    status_nxt = status;
    pay_go     = 1'b0;
    case (state)
      IDLE: if (start) begin
        rem_pay    = amount;
        status_nxt = 2'b00;
        state_nxt  = amount == '0 ? DONE : PAY;
        pay_go     = amount != '0;
      end
      PAY: begin
        if (abort) begin
          state_nxt  = DONE;
          status_nxt = 2'b11;
        end else if (dispense) begin
          state_nxt  = DONE;
          status_nxt = 2'b10;
        end else if (rem == '0) begin
          state_nxt = WAIT;
          cnt_nxt   = '0;
        end else if (COIN_GAP == 0) begin
          pay_go = 1'b1;
        end else begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end
      end
      GAP: begin
        if (abort) begin
          state_nxt  = DONE;
          status_nxt = 2'b11;
        end else if (dispense) begin
          state_nxt  = DONE;
          status_nxt = 2'b10;
        end else if (cnt == CW'(COIN_GAP - 1)) begin
          state_nxt = PAY;
          pay_go    = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WAIT: begin
        if (abort) begin
          state_nxt  = DONE;
          status_nxt = 2'b11;
        end else if (dispense) begin
          state_nxt  = DONE;
          status_nxt = 2'b00;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_nxt  = DONE;
          status_nxt = 2'b01;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // rem holds the amount still unpaid after the coin currently on the bus
  assign coin_nxt  = pay_go ? (rem_pay >= AMT_W'(2) ? 2'b10 : 2'b01) : 2'b00;
  assign rem_nxt   = rem_pay - AMT_W'(coin_nxt);
  assign sent_base = (state == IDLE && start) ? '0 : coins_sent;
  assign sent_nxt  = (pay_go && !(&sent_base)) ? sent_base + 1'b1 : sent_base;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rem        <= '0;
      cnt        <= '0;
      coin       <= 2'b00;
      busy       <= 1'b0;
      done       <= 1'b0;
      status     <= 2'b00;
      coins_sent <= '0;
    end else begin
      state      <= state_nxt;
      rem        <= rem_nxt;
      cnt        <= cnt_nxt;
      coin       <= coin_nxt;
      busy       <= state_nxt == PAY || state_nxt == GAP || state_nxt == WAIT;
      done       <= state_nxt == DONE;
      status     <= status_nxt;
      coins_sent <= sent_nxt;
    end
  end
endmodule

// File: doc/coin_payer.md
Name: coin_payer

Overview:
- Payment-side initiator for the vending machine coin interface. It drives the 2-bit coin code the vending machine consumes and watches the machine's dispense output.
- On a start request it pays a requested amount one coin per cycle, largest coin first. It then waits for dispense, with a timeout, and reports a completion status.
- Used as the stimulus/master end of the coin bus in system-level benches and in the front-panel controller.

Parameters:
- AMT_W, 4, width of amount input, in units of 5 (one nickel)
- COIN_GAP, 0, idle cycles (coin=00) inserted between consecutive coins, range 0..15
- TIMEOUT, 8, maximum cycles spent in WAIT for dispense before reporting timeout, must be >=1

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  request to pay; sampled only in IDLE
- amount  input  AMT_W  amount to pay in nickel units, latched when start is accepted
- abort  input  1  cancel current transaction
- dispense  input  1  from vending machine; product released
- coin  output  2  coin code to vending machine: 00 none, 01 nickel (1 unit), 10 dime (2 units), 11 never driven
- busy  output  1  high in PAY, GAP, WAIT
- done  output  1  one-cycle pulse at end of a transaction
- status  output  2  result, valid with done and held until the next accepted start: 00 ok, 01 timeout, 10 early dispense, 11 aborted
- coins_sent  output  AMT_W  number of coins issued in the current/last transaction

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; coin=00, busy=0, done=0, status=00, coins_sent=0.
  - Outputs go to these values immediately, without waiting for a clock edge, including mid-transaction.
- All outputs are registered.
- States: IDLE, PAY, GAP, WAIT, DONE.
- IDLE:
  - start=1 at an edge: latch remaining=amount, clear coins_sent, set status=00.
  - If amount=0: go to DONE with status 00, no coins issued.
  - Otherwise: go to PAY. The first coin appears on coin in the cycle after the accepting edge (1-cycle latency).
- PAY: each PAY cycle drives exactly one coin for one clock.
  - remaining>=2: coin=10, remaining-=2.
  - remaining=1: coin=01, remaining=0.
  - coins_sent increments with every coin issued.
- After a coin:
  - remaining>0 and COIN_GAP>0: go to GAP for COIN_GAP cycles with coin=00, then PAY.
  - remaining>0 and COIN_GAP=0: stay in PAY (back-to-back coins).
  - remaining=0: go to WAIT with coin=00. No gap is inserted after the last coin.
- WAIT:
  - Wait counter starts at 0 on entry and increments each cycle dispense=0.
  - dispense=1 sampled: go to DONE with status 00.
  - Counter reaches TIMEOUT with no dispense: go to DONE with status 01.
- Early dispense: dispense=1 sampled in PAY or GAP stops payment with no further coins, then DONE with status 10.
- abort=1 sampled in PAY, GAP or WAIT: DONE with status 11; coin=00 from the next cycle.
  - abort has priority over dispense and timeout in the same cycle.
  - abort in IDLE or DONE is ignored.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. start asserted during DONE is ignored.
- start asserted while busy is ignored; the latched amount is not changed.
- coins_sent saturates at its maximum; it cannot overflow for legal amounts since the coin count never exceeds the amount.
- coin is never 11, and is 00 whenever not in PAY.

Test Plan:
- Reset, then start with amount=3, COIN_GAP=0 -> coin=10 then 01 on consecutive cycles, then 00. dispense pulsed 2 cycles later -> done=1, status=00, coins_sent=2.
- amount=4, COIN_GAP=2 -> coin sequence 10,00,00,10,00. No dispense -> after TIMEOUT=8 WAIT cycles: done=1, status=01, coins_sent=2.
- amount=5, dispense=1 asserted during the second coin cycle -> no third coin issued, status=10, coins_sent=2.
- amount=6, abort=1 during the first GAP cycle -> coin stays 00, done pulse with status=11. start re-asserted in the DONE cycle is ignored; start in the following IDLE cycle is accepted.
- amount=0 -> done one cycle after start, status=00, coins_sent=0, coin never leaves 00. start held high while busy does not restart the transaction.
- reset driven low mid-PAY, between clock edges -> coin=00 and busy=0 immediately. After release the block is in IDLE and a new amount=2 transaction completes normally.
